multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control FSM that sequences the ALU, register file, PC and a single shared instruction/data memory port for the RV32I subset core. It latches the fetched instruction, decodes it and drives `ALU_control`, operand/writeback selects and write enables one phase per state. It sits between the memory interface and the datapath (ALU, register file, PC register), which contain no control logic of their own.

## Interface
Parameters:
- `RESET_IR`, 32'h00000013, instruction-register value after reset (NOP).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `mem_rdata`  in  32  memory read word, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the current request this cycle
- `zero`  in  1  ALU zero flag
- `mem_req`  out  1  memory request; held until `mem_ready`
- `mem_we`  out  1  store request (valid with `mem_req`)
- `addr_sel`  out  1  0 = PC, 1 = ALU result as memory address
- `ir`  out  32  latched instruction
- `ALU_control`  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, LUI 1010, AUIPC 1011, JAL 1100, JALR 1101
- `alu_a_sel`  out  1  0 = rs1, 1 = zero
- `alu_b_sel`  out  1  0 = rs2, 1 = immediate
- `imm_sel`  out  3  I=0, S=1, B=2, U=3, J=4
- `rf_we`  out  1  register-file write strobe
- `wb_sel`  out  2  0 = ALU result, 1 = `mem_rdata`, 2 = PC+4
- `pc_we`  out  1  PC write strobe
- `pc_sel`  out  2  0 = PC+4, 1 = ALU result, 2 = PC + B-immediate
- `state`  out  3  current state (debug)
- `halted`  out  1  illegal instruction seen; sticky until reset

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0. When `mem_ready`=1: `ir` <- `mem_rdata`, go to DECODE; otherwise stay in FETCH.
- DECODE: one cycle. Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LW (funct3 010), 0100011 SW (funct3 010), 1100011 BEQ/BNE (funct3 000/001), 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR. Any other opcode or funct3 goes to HALT.
- EXEC: drive `ALU_control` and the operand selects from `ir`. Funct7[5] selects SUB/SRA. I-type SUB does not exist (ADDI uses ADD); SRAI is selected by `ir[30]`.
  - Branch: SUB on rs1/rs2. BEQ is taken if `zero`=1, BNE if `zero`=0. Taken: `pc_sel`=2; not taken: `pc_sel`=0. `pc_we`=1, then FETCH.
  - LW/SW: ADD rs1 + imm (I/S), then MEM.
  - All other instructions: go to WB.
  - LUI and AUIPC use `alu_a_sel`=1 with U-immediate.
  - JAL: B = J-immediate. JALR: A = rs1, B = I-immediate.
- MEM: `ALU_control` held at ADD, `mem_req`=1, `addr_sel`=1, `mem_we`=1 for SW. Wait for `mem_ready`.
  - SW: on ready, `pc_we`=1 with `pc_sel`=0, then FETCH.
  - LW: on ready, go to WB; `mem_rdata` is captured by the datapath via `wb_sel`=1 in WB.
- WB: `ALU_control` held from EXEC.
  - `rf_we`=1 unless rd (`ir[11:7]`)=0.
  - `wb_sel`: ALU result for R/I/LUI/AUIPC, `mem_rdata` for LW, PC+4 for JAL/JALR.
  - `pc_we`=1. `pc_sel`=1 for JAL/JALR (ALU computes the target); `pc_sel`=0 otherwise.
  - Then FETCH.
- HALT: all strobes and `mem_req` are 0 and `halted`=1 until `rst`.
- Combinational outputs: decoded from `state` and `ir`. `pc_we` in MEM is qualified by `mem_ready`.

## Timing
- Reset: `state`=FETCH, `ir`=`RESET_IR`, `halted`=0. While `rst`=1, `mem_req`, `mem_we`, `rf_we`, `pc_we` = 0, `ALU_control`=0000, and all selects = 0. `mem_req` rises in the first cycle after `rst` deasserts.
- Reset mid-MEM or mid-FETCH: the request is abandoned and no write strobe is issued. A `mem_ready` arriving during `rst` is ignored.
- `mem_ready` is sampled only while `mem_req`=1. `mem_req`, `addr_sel` and `mem_we` remain stable until the ready cycle.
- Cycles per instruction with zero-wait memory: branch 3, ALU/LUI/AUIPC/JAL/JALR 4, SW 4, LW 5. Each memory wait cycle adds 1.
- Exactly one `pc_we` pulse per retired instruction. At most one `rf_we` pulse per instruction, always in WB.

## Test plan
- ADD x3,x1,x2 (0x002081B3), ready immediately -> states 0,1,2,4; `ALU_control`=0000 in EXEC; `rf_we`=1 and `pc_we`=1 with `pc_sel`=0 in WB; 4 cycles total.
- BEQ with `zero`=1, then the same instruction with `zero`=0 -> EXEC `ALU_control`=0001, `pc_sel`=2 then 0, `pc_we`=1, `rf_we` never asserted; 3 cycles each.
- LW with `mem_ready` delayed 2 cycles in MEM -> `mem_req`=1, `addr_sel`=1, `mem_we`=0 held for 3 cycles; WB `wb_sel`=1 and `rf_we`=1; 7 cycles total.
- JAL x1 (0x008000EF) -> EXEC `ALU_control`=1100; WB `wb_sel`=2, `pc_sel`=1, `rf_we`=1. ADDI x0 -> `rf_we`=0 and `pc_we`=1.
- Opcode 0x0000007F -> DECODE to HALT; `halted`=1 and `mem_req`=0 indefinitely. `rst` returns `state` to 0 with `halted`=0.
- `rst` asserted in SW MEM before ready -> `mem_we` and `pc_we` never pulse, `ir`=0x00000013, and FETCH restarts.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core: fetch, decode, execute,
// memory and write-back phases sharing one instruction/data memory port.
module multi_cycle_ctrl #(
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [31:0] ir,
  output logic [3:0]  ALU_control,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_AUIPC = 4'b1011;
  localparam logic [3:0] ALU_JAL   = 4'b1100;
  localparam logic [3:0] ALU_JALR  = 4'b1101;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        halted_q, halted_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic       legal;

  always_comb begin
    opcode   = ir_q[6:0];
    funct3   = ir_q[14:12];
    rd       = ir_q[11:7];
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    is_sw    = (opcode == OP_STORE)  && (funct3 == 3'b010);
    is_br    = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR)   && (funct3 == 3'b000);
    legal    = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_auipc | is_jal | is_jalr;
  end

  // Datapath configuration for the instruction in ir; held from EXEC through WB
  // so the ALU result stays stable while it is used as address or write data.
  logic [3:0] cfg_alu;
  logic       cfg_a_sel;
  logic       cfg_b_sel;
  logic [2:0] cfg_imm;

  always_comb begin
    cfg_alu   = ALU_ADD;
    cfg_a_sel = 1'b0;
    cfg_b_sel = 1'b0;
    cfg_imm   = IMM_I;
    if (is_r || is_i) begin
      cfg_b_sel = is_i;
      case (funct3)
        3'b000:  cfg_alu = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  cfg_alu = ALU_SLL;
        3'b010:  cfg_alu = ALU_SLT;
        3'b011:  cfg_alu = ALU_SLTU;
        3'b100:  cfg_alu = ALU_XOR;
        3'b101:  cfg_alu = ir_q[30] ? ALU_SRA : ALU_SRL;
        3'b110:  cfg_alu = ALU_OR;
        default: cfg_alu = ALU_AND;
      endcase
    end else if (is_lw) begin
      cfg_b_sel = 1'b1;
    end else if (is_sw) begin
      cfg_b_sel = 1'b1;
      cfg_imm   = IMM_S;
    end else if (is_br) begin
      cfg_alu   = ALU_SUB;
      cfg_imm   = IMM_B;
    end else if (is_lui || is_auipc) begin
      cfg_alu   = is_lui ? ALU_LUI : ALU_AUIPC;
      cfg_a_sel = 1'b1;
      cfg_b_sel = 1'b1;
      cfg_imm   = IMM_U;
    end else if (is_jal) begin
      cfg_alu   = ALU_JAL;
      cfg_b_sel = 1'b1;
      cfg_imm   = IMM_J;
    end else if (is_jalr) begin
      cfg_alu   = ALU_JALR;
      cfg_b_sel = 1'b1;
    end
  end

  logic br_taken;
  assign br_taken = funct3[0] ? ~zero : zero;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_br)               state_d = ST_FETCH;
        else if (is_lw || is_sw) state_d = ST_MEM;
        else                     state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) state_d = is_sw ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= RESET_IR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Strobes and selects are forced low for the whole reset cycle, even before
  // state_q has been cleared, so an abandoned request never produces a write.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ALU_control = ALU_ADD;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    imm_sel     = IMM_I;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    if (!rst) begin
      case (state_q)
        ST_FETCH: mem_req = 1'b1;
        ST_EXEC: begin
          ALU_control = cfg_alu;
          alu_a_sel   = cfg_a_sel;
          alu_b_sel   = cfg_b_sel;
          imm_sel     = cfg_imm;
          if (is_br) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
          end
        end
        ST_MEM: begin
          mem_req     = 1'b1;
          addr_sel    = 1'b1;
          mem_we      = is_sw;
          ALU_control = ALU_ADD;
          alu_a_sel   = cfg_a_sel;
          alu_b_sel   = cfg_b_sel;
          imm_sel     = cfg_imm;
          pc_we       = is_sw & mem_ready;
        end
        ST_WB: begin
          ALU_control = cfg_alu;
          alu_a_sel   = cfg_a_sel;
          alu_b_sel   = cfg_b_sel;
          imm_sel     = cfg_imm;
          rf_we       = (rd != 5'd0);
          if (is_lw)                 wb_sel = WB_MEM;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          pc_we  = 1'b1;
          pc_sel = (is_jal || is_jalr) ? PC_ALU : PC_PLUS4;
        end
        default: ;
      endcase
    end
  end

  assign ir     = ir_q;
  assign state  = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expected control vectors are
// queued for each instruction and compared as the FSM steps through it.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        zero;
  logic        mem_req, mem_we, addr_sel;
  logic [31:0] ir;
  logic [3:0]  ALU_control;
  logic        alu_a_sel, alu_b_sel;
  logic [2:0]  imm_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted;

  multi_cycle_ctrl #(.RESET_IR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir),
    .ALU_control(ALU_control), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, addr;
    logic [3:0] alu;
    logic       a, b;
    logic [2:0] imm;
    logic       rf;
    logic [1:0] wb;
    logic       pcwe;
    logic [1:0] pcs;
    logic       hlt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    compared = 0;
  int    mismatched = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic addr, input logic [3:0] alu, input logic a,
                              input logic b, input logic [2:0] imm, input logic rf,
                              input logic [1:0] wb, input logic pcwe,
                              input logic [1:0] pcs, input logic hlt);
    exp_t e;
    e = '{st, req, we, addr, alu, a, b, imm, rf, wb, pcwe, pcs, hlt};
    return e;
  endfunction

  task automatic push(input string t, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_output();
    exp_t  e, o;
    string t;
    o = '{state, mem_req, mem_we, addr_sel, ALU_control, alu_a_sel, alu_b_sel,
          imm_sel, rf_we, wb_sel, pc_we, pc_sel, halted};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL sb_empty: observed=%h required=<nothing queued>", o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed=%h required=%h", t, o, e);
      end
    end
  endtask

  task automatic check_ir(input string t, input logic [31:0] expv);
    compared++;
    assert (ir === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed ir=%h required=%h", t, ir, expv);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy, input logic [31:0] rd,
                                input logic z);
    rst       = r;
    mem_ready = rdy;
    mem_rdata = rd;
    zero      = z;
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fd(input string name);
    push({name, "_fetch"},  mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    push({name, "_decode"}, mk(3'd1, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
  endtask

  // Four-cycle FETCH/DECODE/EXEC/WB instruction with immediate memory.
  task automatic run_wb_instr(input string name, input logic [31:0] instr,
                              input logic [3:0] alu, input logic a, input logic b,
                              input logic [2:0] imm, input logic rf, input logic [1:0] wb,
                              input logic [1:0] pcs);
    push_fd(name);
    push({name, "_exec"}, mk(3'd2, 0, 0, 0, alu, a, b, imm, 0, 2'd0, 0, 2'd0, 0));
    push({name, "_wb"},   mk(3'd4, 0, 0, 0, alu, a, b, imm, rf, wb, 1, pcs, 0));
    apply_stimulus(0, 1, instr, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    check_ir({name, "_ir"}, instr);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
  endtask

  task automatic run_branch(input string name, input logic [31:0] instr, input logic z,
                            input logic [1:0] pcs);
    push_fd(name);
    push({name, "_exec"}, mk(3'd2, 0, 0, 0, 4'b0001, 0, 0, 3'd2, 0, 2'd0, 1, pcs, 0));
    apply_stimulus(0, 1, instr, z);
    apply_stimulus(0, 0, 32'h0, z);
    apply_stimulus(0, 0, 32'h0, z);
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRA   = 32'h4020D1B3;
  localparam logic [31:0] I_SRAI  = 32'h4020D193;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LW    = 32'h0040A283;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_NOP   = 32'h00000013;
  localparam logic [31:0] I_LD    = 32'h0040B283;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  initial begin
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; zero = 1'b0;

    // Reset with a stray ready/rdata present: nothing may be captured.
    push("reset0", mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    push("reset1", mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    apply_stimulus(1, 1, 32'hDEADBEEF, 0);
    apply_stimulus(1, 1, 32'hDEADBEEF, 0);
    check_ir("reset_ir", 32'h00000013);

    run_wb_instr("add",  I_ADD,  4'b0000, 0, 0, 3'd0, 1, 2'd0, 2'd0);
    run_wb_instr("sra",  I_SRA,  4'b0111, 0, 0, 3'd0, 1, 2'd0, 2'd0);
    run_wb_instr("srai", I_SRAI, 4'b0111, 0, 1, 3'd0, 1, 2'd0, 2'd0);
    run_wb_instr("lui",  I_LUI,  4'b1010, 1, 1, 3'd3, 1, 2'd0, 2'd0);

    run_branch("beq_taken", I_BEQ, 1'b1, 2'd2);
    run_branch("beq_not",   I_BEQ, 1'b0, 2'd0);

    // LW with a one-cycle fetch wait and two MEM wait cycles.
    push("lw_fetch_wait", mk(3'd0, 1, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    push_fd("lw");
    push("lw_exec", mk(3'd2, 0, 0, 0, 4'd0, 0, 1, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    for (int i = 0; i < 3; i++)
      push("lw_mem", mk(3'd3, 1, 0, 1, 4'd0, 0, 1, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    push("lw_wb", mk(3'd4, 0, 0, 0, 4'd0, 0, 1, 3'd0, 1, 2'd1, 1, 2'd0, 0));
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 1, I_LW, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h55AA55AA, 0);
    apply_stimulus(0, 0, 32'h0, 0);

    run_wb_instr("jal",  I_JAL, 4'b1100, 0, 1, 3'd4, 1, 2'd2, 2'd1);
    run_wb_instr("addi_x0", I_NOP, 4'b0000, 0, 1, 3'd0, 0, 2'd0, 2'd0);

    // SW completing with zero-wait memory.
    push_fd("sw");
    push("sw_exec", mk(3'd2, 0, 0, 0, 4'd0, 0, 1, 3'd1, 0, 2'd0, 0, 2'd0, 0));
    push("sw_mem",  mk(3'd3, 1, 1, 1, 4'd0, 0, 1, 3'd1, 0, 2'd0, 1, 2'd0, 0));
    apply_stimulus(0, 1, I_SW, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h0, 0);

    // SW aborted by reset while waiting in MEM; ready arrives during reset.
    push_fd("sw_abort");
    push("sw_abort_exec", mk(3'd2, 0, 0, 0, 4'd0, 0, 1, 3'd1, 0, 2'd0, 0, 2'd0, 0));
    push("sw_abort_mem",  mk(3'd3, 1, 1, 1, 4'd0, 0, 1, 3'd1, 0, 2'd0, 0, 2'd0, 0));
    push("sw_abort_rst0", mk(3'd3, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    push("sw_abort_rst1", mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    apply_stimulus(0, 1, I_SW, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(1, 1, 32'hFFFFFFFF, 0);
    apply_stimulus(1, 1, 32'hFFFFFFFF, 0);
    check_ir("sw_abort_ir", 32'h00000013);

    // LW encoding with an unsupported funct3 must halt.
    push_fd("ld");
    push("ld_halt", mk(3'd7, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 1));
    push("ld_rst0", mk(3'd7, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 1));
    push("ld_rst1", mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    apply_stimulus(0, 1, I_LD, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0);

    // Illegal opcode: sticky halt, ignores ready, cleared only by reset.
    push_fd("ill");
    for (int i = 0; i < 5; i++)
      push("ill_halt", mk(3'd7, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 1));
    push("ill_rst0", mk(3'd7, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 1));
    push("ill_rst1", mk(3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    apply_stimulus(0, 1, I_ILL, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 1, I_ADD, 0);
    apply_stimulus(1, 0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0);

    run_wb_instr("add_after_halt", I_ADD, 4'b0000, 0, 0, 3'd0, 1, 2'd0, 2'd0);

    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL sb_drain: observed %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
